// File: rtl/wb2axil_bridge.sv
// Wishbone B4 pipelined single-access slave to AXI4-Lite master bridge.
// One transaction in flight, byte strobes from sel, and a response timeout that drains the outstanding AXI beat.
module wb2axil_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_addr_i,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic                    wb_stall_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $error("wb2axil_bridge: DATA_WIDTH must be 32 or 64");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DRAIN} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [SW-1:0]         sel;
  } req_t;

  state_t                state;
  req_t                  req;
  logic [CW-1:0]         cnt;
  logic                  aw_done, w_done;
  logic                  abandon;
  logic                  stall_q, ack_q, err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic accept, aw_hs, w_hs, ar_hs, live, active, timeout_hit, b_ok, r_ok;

  assign accept = (state == IDLE) && !stall_q && wb_cyc_i && wb_stb_i;
  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  // A completion is reported only to a master that is still holding the cycle.
  assign live   = wb_cyc_i && !abandon;
  assign active = (state == WR) || (state == WR_RESP) || (state == RD_ADDR) || (state == RD_DATA);
  assign b_ok   = (m_axi_bresp == 2'b00) || (m_axi_bresp == 2'b01);
  assign r_ok   = (m_axi_rresp == 2'b00) || (m_axi_rresp == 2'b01);

  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES > 0)
      timeout_hit = active && (32'(cnt) >= TIMEOUT_CYCLES - 1);
  end

  assign wb_stall_o   = stall_q;
  assign wb_ack_o     = ack_q && wb_cyc_i;
  assign wb_err_o     = err_q && wb_cyc_i;
  assign wb_data_o    = rdata_q;
  assign m_axi_awaddr = req.addr;
  assign m_axi_araddr = req.addr;
  assign m_axi_wdata  = req.data;
  assign m_axi_wstrb  = req.sel;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state         <= IDLE;
      req           <= '0;
      cnt           <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      abandon       <= 1'b0;
      stall_q       <= 1'b1;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (active) cnt <= cnt + 1'b1;
      if (state != IDLE && !wb_cyc_i) abandon <= 1'b1;

      case (state)
        IDLE: begin
          abandon <= 1'b0;
          stall_q <= 1'b0;
          if (accept) begin
            req.we   <= wb_we_i;
            req.addr <= {wb_addr_i[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
            req.data <= wb_data_i;
            req.sel  <= wb_sel_i;
            stall_q  <= 1'b1;
            cnt      <= '0;
            if (wb_we_i) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end

        WR: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end else if (timeout_hit) begin
            m_axi_bready <= 1'b1;
            err_q        <= live;
            state        <= DRAIN;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            ack_q        <= live && b_ok;
            err_q        <= live && !b_ok;
            stall_q      <= live;
            state        <= IDLE;
          end else if (timeout_hit) begin
            err_q <= live;
            state <= DRAIN;
          end
        end

        RD_ADDR: begin
          if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end else if (timeout_hit) begin
            m_axi_rready <= 1'b1;
            err_q        <= live;
            state        <= DRAIN;
          end
        end

        RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rdata_q      <= m_axi_rdata;
            ack_q        <= live && r_ok;
            err_q        <= live && !r_ok;
            stall_q      <= live;
            state        <= IDLE;
          end else if (timeout_hit) begin
            err_q <= live;
            state <= DRAIN;
          end
        end

        DRAIN: begin
          // Valids already on the bus stay up until accepted; the late response is dropped.
          if (aw_hs) m_axi_awvalid <= 1'b0;
          if (w_hs)  m_axi_wvalid  <= 1'b0;
          if (ar_hs) m_axi_arvalid <= 1'b0;
          if (req.we && m_axi_bvalid && m_axi_bready) begin
            m_axi_bready  <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            stall_q       <= 1'b0;
            state         <= IDLE;
          end else if (!req.we && m_axi_rvalid && m_axi_rready) begin
            m_axi_rready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            stall_q       <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb2axil_bridge.sv
// Directed bench: 32-bit bridge with a short timeout plus a 64-bit bridge against an auto-responding slave.
module tb_wb2axil_bridge;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // 32-bit instance
  logic        cyc, stb, we, stall, ack, err;
  logic [31:0] addr, wdat, rdat_o;
  logic [3:0]  sel;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic [1:0]  bresp, rresp;

  wb2axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_addr_i(addr), .wb_data_i(wdat), .wb_sel_i(sel),
    .wb_stall_o(stall), .wb_ack_o(ack), .wb_err_o(err), .wb_data_o(rdat_o),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );

  // 64-bit instance, slave answers immediately
  logic        x_cyc, x_stb, x_we, x_stall, x_ack, x_err;
  logic [31:0] x_addr, x_awaddr, x_araddr;
  logic [63:0] x_wdat, x_rdat_o, x_wdata;
  logic [7:0]  x_sel, x_wstrb;
  logic        x_awvalid, x_wvalid, x_bready, x_arvalid, x_rready;
  logic [2:0]  x_awprot, x_arprot;

  wb2axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(256)) dut64 (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .wb_cyc_i(x_cyc), .wb_stb_i(x_stb), .wb_we_i(x_we), .wb_addr_i(x_addr), .wb_data_i(x_wdat), .wb_sel_i(x_sel),
    .wb_stall_o(x_stall), .wb_ack_o(x_ack), .wb_err_o(x_err), .wb_data_o(x_rdat_o),
    .m_axi_awvalid(x_awvalid), .m_axi_awready(1'b1), .m_axi_awaddr(x_awaddr), .m_axi_awprot(x_awprot),
    .m_axi_wvalid(x_wvalid), .m_axi_wready(1'b1), .m_axi_wdata(x_wdata), .m_axi_wstrb(x_wstrb),
    .m_axi_bvalid(x_bready), .m_axi_bready(x_bready), .m_axi_bresp(2'b00),
    .m_axi_arvalid(x_arvalid), .m_axi_arready(1'b1), .m_axi_araddr(x_araddr), .m_axi_arprot(x_arprot),
    .m_axi_rvalid(x_rready), .m_axi_rready(x_rready), .m_axi_rdata(64'h0), .m_axi_rresp(2'b00)
  );

  initial begin
    rst_n = 1'b0;
    cyc = 0; stb = 0; we = 0; addr = '0; wdat = '0; sel = '0;
    awready = 1; wready = 1; bvalid = 0; bresp = 2'b00;
    arready = 1; rvalid = 0; rdata = '0; rresp = 2'b00;
    x_cyc = 0; x_stb = 0; x_we = 0; x_addr = '0; x_wdat = '0; x_sel = '0;

    // reset state
    tick();
    chk("rst_stall", 64'(stall), 64'h1);
    chk("rst_awvalid", 64'(awvalid), 64'h0);
    chk("rst_arvalid", 64'(arvalid), 64'h0);
    chk("rst_bready", 64'(bready), 64'h0);
    chk("rst_ack_err", 64'({ack, err}), 64'h0);
    chk("rst_data", 64'(rdat_o), 64'h0);
    chk("rst_awaddr", 64'(awaddr), 64'h0);
    chk("rst_prot", 64'({awprot, arprot}), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_stall", 64'(stall), 64'h0);
    chk("idle_stall64", 64'(x_stall), 64'h0);

    // 64-bit: address aligned down to 8 bytes, strobes pass through
    x_cyc = 1; x_stb = 1; x_we = 1; x_addr = 32'h1C; x_sel = 8'hF0; x_wdat = 64'h1122_3344_5566_7788;
    tick();
    x_stb = 0;
    chk("w64_awaddr", 64'(x_awaddr), 64'h18);
    chk("w64_wstrb", 64'(x_wstrb), 64'hF0);
    chk("w64_wdata", x_wdata, 64'h1122_3344_5566_7788);
    chk("w64_valids", 64'({x_awvalid, x_wvalid}), 64'h3);
    tick();
    chk("w64_bready", 64'(x_bready), 64'h1);
    tick();
    chk("w64_ack", 64'({x_ack, x_err}), 64'h2);
    x_cyc = 0;
    tick();

    // T1: zero-wait write
    cyc = 1; stb = 1; we = 1; addr = 32'h4; wdat = 32'hAF; sel = 4'hF;
    chk("t1_c0_stall", 64'(stall), 64'h0);
    tick();
    stb = 0;
    chk("t1_c1_valids", 64'({awvalid, wvalid}), 64'h3);
    chk("t1_c1_awaddr", 64'(awaddr), 64'h4);
    chk("t1_c1_wdata", 64'(wdata), 64'hAF);
    chk("t1_c1_wstrb", 64'(wstrb), 64'hF);
    chk("t1_c1_stall", 64'(stall), 64'h1);
    chk("t1_c1_ack", 64'(ack), 64'h0);
    tick();
    chk("t1_c2_bready", 64'(bready), 64'h1);
    chk("t1_c2_valids", 64'({awvalid, wvalid}), 64'h0);
    chk("t1_c2_stall", 64'(stall), 64'h1);
    chk("t1_c2_ack", 64'(ack), 64'h0);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    chk("t1_c3_ack_err", 64'({ack, err}), 64'h2);
    chk("t1_c3_stall", 64'(stall), 64'h1);
    chk("t1_c3_bready", 64'(bready), 64'h0);
    tick();
    chk("t1_c4_ack", 64'(ack), 64'h0);
    chk("t1_c4_stall", 64'(stall), 64'h0);

    // T2: awready delayed, wready immediate
    stb = 1; we = 1; addr = 32'h10; wdat = 32'h55; sel = 4'h3; awready = 0;
    tick();
    stb = 0;
    chk("t2_c1_valids", 64'({awvalid, wvalid}), 64'h3);
    tick();
    chk("t2_c2_valids", 64'({awvalid, wvalid}), 64'h2);
    chk("t2_c2_ack", 64'(ack), 64'h0);
    tick();
    chk("t2_c3_valids", 64'({awvalid, wvalid}), 64'h2);
    awready = 1;
    tick();
    chk("t2_c4_valids", 64'({awvalid, wvalid}), 64'h0);
    chk("t2_c4_bready", 64'(bready), 64'h1);
    chk("t2_c4_ack", 64'(ack), 64'h0);
    bvalid = 1; bresp = 2'b01;
    tick();
    bvalid = 0;
    chk("t2_c5_ack_err", 64'({ack, err}), 64'h2);
    tick();
    chk("t2_c6_ack", 64'(ack), 64'h0);

    // T3: read with SLVERR still returns data
    stb = 1; we = 0; addr = 32'h8;
    chk("t3_c0_stall", 64'(stall), 64'h0);
    tick();
    stb = 0;
    chk("t3_c1_arvalid", 64'(arvalid), 64'h1);
    chk("t3_c1_araddr", 64'(araddr), 64'h8);
    tick();
    chk("t3_c2_rready", 64'(rready), 64'h1);
    chk("t3_c2_arvalid", 64'(arvalid), 64'h0);
    rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b10;
    tick();
    rvalid = 0;
    chk("t3_c3_ack_err", 64'({ack, err}), 64'h1);
    chk("t3_c3_data", 64'(rdat_o), 64'h1234_5678);
    tick();
    chk("t3_c4_err", 64'(err), 64'h0);
    chk("t3_c4_data", 64'(rdat_o), 64'h1234_5678);

    // T4: write response never comes until cycle 40
    stb = 1; we = 1; addr = 32'h20; wdat = 32'h1; sel = 4'hF;
    tick();
    stb = 0;
    for (int k = 2; k <= 40; k++) begin
      tick();
      chk($sformatf("t4_c%0d_err", k), 64'(err), 64'(k == 17));
      chk($sformatf("t4_c%0d_ack", k), 64'(ack), 64'h0);
      chk($sformatf("t4_c%0d_stall", k), 64'(stall), 64'h1);
      if (k >= 2) chk($sformatf("t4_c%0d_bready", k), 64'(bready), 64'h1);
    end
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    chk("t4_c41_stall", 64'(stall), 64'h0);
    chk("t4_c41_ack_err", 64'({ack, err}), 64'h0);
    chk("t4_c41_bready", 64'(bready), 64'h0);
    stb = 1; we = 0; addr = 32'hC;
    tick();
    stb = 0;
    chk("t4_c42_arvalid", 64'(arvalid), 64'h1);
    chk("t4_c42_araddr", 64'(araddr), 64'hC);
    tick();
    chk("t4_c43_rready", 64'(rready), 64'h1);
    rvalid = 1; rdata = 32'hCAFE; rresp = 2'b00;
    tick();
    rvalid = 0;
    chk("t4_c44_ack_err", 64'({ack, err}), 64'h2);
    chk("t4_c44_data", 64'(rdat_o), 64'hCAFE);
    tick();

    // T5: master drops cyc mid-write
    stb = 1; we = 1; addr = 32'h4;
    tick();
    stb = 0; cyc = 0;
    tick();
    chk("t5_c2_bready", 64'(bready), 64'h1);
    bvalid = 1;
    tick();
    bvalid = 0;
    chk("t5_c3_ack_err", 64'({ack, err}), 64'h0);
    cyc = 1;
    tick();
    chk("t5_c4_ack_err", 64'({ack, err}), 64'h0);
    chk("t5_c4_stall", 64'(stall), 64'h0);

    // T6: reset during WR_RESP
    stb = 1; we = 1; addr = 32'h30; wdat = 32'h77;
    tick();
    stb = 0;
    tick();
    chk("t6_bready_pre", 64'(bready), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'h0);
    chk("t6_rst_ack_err", 64'({ack, err}), 64'h0);
    chk("t6_rst_stall", 64'(stall), 64'h1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_idle_stall", 64'(stall), 64'h0);
    chk("t6_idle_bready", 64'(bready), 64'h0);
    stb = 1; we = 1; addr = 32'h40; wdat = 32'h99;
    tick();
    stb = 0;
    chk("t6_w_valids", 64'({awvalid, wvalid}), 64'h3);
    tick();
    bvalid = 1;
    tick();
    bvalid = 0;
    chk("t6_w_ack", 64'({ack, err}), 64'h2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
